// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: synchronise, debounce, edge-detect, long-press, auto-repeat, toggle.
// Latency: 2-flop synchroniser plus DB_CYC stable cycles before level moves; edge pulses follow level by 0 cycles.
// Backpressure: none; every output is a free-running level or 1-cycle pulse with no handshake.
//
// Ports:
//   clk_50_i       system clock
//   rst_i          synchronous active-high reset
//   btn_raw_i      asynchronous, bouncing button pins (polarity set per channel by ACTIVE_LOW)
//   level_o        debounced pressed state
//   press_o        1-cycle pulse when level rises
//   release_o      1-cycle pulse when level falls
//   long_press_o   1-cycle pulse once per hold reaching LONG_MS
//   repeat_o       1-cycle pulse every REPEAT_MS after long_press_o while still held
//   toggle_o       flips on every press
module button_conditioner #(
  parameter int               N_BTN       = 4,
  parameter int               CLK_HZ      = 50_000_000,
  parameter int               DEBOUNCE_MS = 5,
  parameter int               LONG_MS     = 1000,
  parameter int               REPEAT_MS   = 200,
  parameter logic [N_BTN-1:0] ACTIVE_LOW  = '0
) (
  input  logic             clk_50_i,
  input  logic             rst_i,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] long_press_o,
  output logic [N_BTN-1:0] repeat_o,
  output logic [N_BTN-1:0] toggle_o
);

  localparam int DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CYC = CLK_HZ / 1000 * LONG_MS;
  localparam int REP_CYC  = CLK_HZ / 1000 * REPEAT_MS;
  localparam bit REP_EN   = (REPEAT_MS > 0);
  // Keeps the repeat counter at least one bit wide when repeat is disabled.
  localparam int REP_MAX  = (REP_CYC > 0) ? REP_CYC : 1;

  localparam int DW = $clog2(DB_CYC + 1);
  localparam int HW = $clog2(LONG_CYC + 1);
  localparam int RW = $clog2(REP_MAX + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYC - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REP_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT,
    S_DONE
  } state_e;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          meta_q, sync_q;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic          toggle_q;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    state_e        state_q, state_d;
    logic          press_w, release_w, long_w, rep_w;

    // Debouncer: any cycle where sync agrees with level restarts the count,
    // so only DB_CYC consecutive disagreeing cycles move level.
    always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      if (sync_q != level_q) begin
        if (db_cnt_q == DB_LAST) begin
          level_d = sync_q;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    assign press_w   = level_q & ~level_prev_q;
    assign release_w = ~level_q & level_prev_q;

    always_ff @(posedge clk_50_i) begin
      if (rst_i) begin
        meta_q       <= 1'b0;
        sync_q       <= 1'b0;
        level_q      <= 1'b0;
        level_prev_q <= 1'b0;
        db_cnt_q     <= '0;
        toggle_q     <= 1'b0;
      end else begin
        meta_q       <= btn_raw_i[i] ^ ACTIVE_LOW[i];
        sync_q       <= meta_q;
        level_q      <= level_d;
        level_prev_q <= level_q;
        db_cnt_q     <= db_cnt_d;
        toggle_q     <= toggle_q ^ press_w;
      end
    end

    // Hold FSM: state register
    always_ff @(posedge clk_50_i) begin
      if (rst_i) begin
        state_q    <= S_IDLE;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
      end else begin
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        rep_cnt_q  <= rep_cnt_d;
      end
    end

    // Hold FSM: next state. A release overrides every state.
    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      if (!level_q) begin
        state_d    = S_IDLE;
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (press_w) begin
              state_d    = S_HOLD;
              hold_cnt_d = '0;
              rep_cnt_d  = '0;
            end
          end
          S_HOLD: begin
            if (hold_cnt_q == LONG_LAST) begin
              state_d = REP_EN ? S_REPEAT : S_DONE;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
          S_REPEAT: begin
            if (rep_cnt_q == REP_LAST) begin
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
          S_DONE: begin
            state_d = S_DONE;
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end

    // Hold FSM: outputs. Gating with level suppresses pulses in the release cycle,
    // where the state register has not yet returned to IDLE.
    always_comb begin
      long_w = 1'b0;
      rep_w  = 1'b0;
      if (level_q) begin
        long_w = (state_q == S_HOLD)   && (hold_cnt_q == LONG_LAST);
        rep_w  = (state_q == S_REPEAT) && (rep_cnt_q == REP_LAST);
      end
    end

    assign level_o[i]      = level_q;
    assign press_o[i]      = press_w;
    assign release_o[i]    = release_w;
    assign long_press_o[i] = long_w;
    assign repeat_o[i]     = rep_w;
    assign toggle_o[i]     = toggle_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: stimulus table plus hand sequences, expected pulses queued by cycle.
module tb_button_conditioner;

  localparam int          DB   = 4;
  localparam int          LONG = 20;
  localparam int          REP  = 5;
  localparam int          LAT  = DB + 2;  // drive after edge e -> level moves after edge e+LAT
  localparam logic [3:0]  AL   = 4'b1000;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;
  localparam int K_REP   = 3;

  logic       clk;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] level_o, press_o, release_o, long_o, rep_o, tog_o;
  logic [3:0] level2, press2, release2, long2, rep2, tog2;

  button_conditioner #(
    .N_BTN(4), .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .REPEAT_MS(5), .ACTIVE_LOW(AL)
  ) dut (
    .clk_50_i(clk), .rst_i(rst), .btn_raw_i(btn_raw),
    .level_o(level_o), .press_o(press_o), .release_o(release_o),
    .long_press_o(long_o), .repeat_o(rep_o), .toggle_o(tog_o)
  );

  button_conditioner #(
    .N_BTN(4), .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .REPEAT_MS(0), .ACTIVE_LOW(AL)
  ) dut_norep (
    .clk_50_i(clk), .rst_i(rst), .btn_raw_i(btn_raw),
    .level_o(level2), .press_o(press2), .release_o(release2),
    .long_press_o(long2), .repeat_o(rep2), .toggle_o(tog2)
  );

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  typedef struct {
    int ch;
    int hold;
    int exp_press;
    int exp_long;
    int exp_rep;
  } vec_t;

  ev_t  q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;
  logic rst_edge = 1'b0;
  logic [3:0] exp_lvl = '0;
  logic [3:0] exp_tog = '0;
  int   act_press[4];
  int   act_long[4];
  int   act_rep[4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) tick(1);
  endtask

  // Queue the pulses a clean hold produces: drive after edge e, release drive h edges later.
  task automatic push_hold(input int ch, input int e, input int h);
    int p, r;
    if (h >= DB) begin
      p = e + LAT;
      r = e + h + LAT;
      push_ev(p, ch, K_PRESS);
      push_ev(r, ch, K_REL);
      if (p + LONG < r) push_ev(p + LONG, ch, K_LONG);
      for (int n = 1; p + LONG + REP * n < r; n++) push_ev(p + LONG + REP * n, ch, K_REP);
    end
  endtask

  // Per-cycle check of every output against the queued events.
  always @(negedge clk) begin
    logic [3:0] ep, er, el, erp;
    if (mon_en) begin
      ep = '0; er = '0; el = '0; erp = '0;
      foreach (q[k]) begin
        if (q[k].cyc == cyc) begin
          case (q[k].kind)
            K_PRESS: ep[q[k].ch]  = 1'b1;
            K_REL:   er[q[k].ch]  = 1'b1;
            K_LONG:  el[q[k].ch]  = 1'b1;
            default: erp[q[k].ch] = 1'b1;
          endcase
        end
      end
      for (int k = q.size() - 1; k >= 0; k--) if (q[k].cyc == cyc) q.delete(k);
      if (rst_edge) begin
        exp_lvl = '0;
        exp_tog = '0;
      end
      exp_lvl = (exp_lvl | ep) & ~er;
      chk("level", level_o, exp_lvl);
      chk("press", press_o, ep);
      chk("release", release_o, er);
      chk("long_press", long_o, el);
      chk("repeat", rep_o, erp);
      chk("toggle", tog_o, exp_tog);
      chk("norep_level", level2, exp_lvl);
      chk("norep_long", long2, el);
      chk("norep_repeat", rep2, 4'b0000);
      exp_tog = exp_tog ^ ep;
      for (int c = 0; c < 4; c++) begin
        if (press_o[c] === 1'b1) act_press[c]++;
        if (long_o[c] === 1'b1)  act_long[c]++;
        if (rep_o[c] === 1'b1)   act_rep[c]++;
      end
    end
  end

  initial begin
    vec_t tbl[6];
    int   e, p, r, rs, pc, lc, rc, len;
    bit   v;
    logic [3:0] tog_before;

    tbl[0] = '{0, 20, 1, 0, 0};  // clean press/release; long would land on the release cycle
    tbl[1] = '{2, 50, 1, 1, 5};  // long press then five repeats
    tbl[2] = '{3, 10, 1, 0, 0};  // active-low channel
    tbl[3] = '{1,  3, 0, 0, 0};  // shorter than debounce
    tbl[4] = '{1,  4, 1, 0, 0};  // exactly debounce length
    tbl[5] = '{2, 25, 1, 1, 0};  // first repeat would land on the release cycle

    for (int c = 0; c < 4; c++) begin
      act_press[c] = 0;
      act_long[c]  = 0;
      act_rep[c]   = 0;
    end

    rst     = 1'b1;
    btn_raw = AL;
    tick(1);
    mon_en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);

    // Table-driven holds
    for (int i = 0; i < 6; i++) begin
      pc = act_press[tbl[i].ch];
      lc = act_long[tbl[i].ch];
      rc = act_rep[tbl[i].ch];
      e  = cyc;
      push_hold(tbl[i].ch, e, tbl[i].hold);
      btn_raw[tbl[i].ch] = ~AL[tbl[i].ch];
      tick(tbl[i].hold);
      btn_raw[tbl[i].ch] = AL[tbl[i].ch];
      to_cyc(e + tbl[i].hold + LAT + 8);
      chk_int($sformatf("tbl%0d_press_cnt", i), act_press[tbl[i].ch] - pc, tbl[i].exp_press);
      chk_int($sformatf("tbl%0d_long_cnt", i), act_long[tbl[i].ch] - lc, tbl[i].exp_long);
      chk_int($sformatf("tbl%0d_rep_cnt", i), act_rep[tbl[i].ch] - rc, tbl[i].exp_rep);
    end

    // Bounce on channel 1: runs of 1-3 cycles never reach the debounce count
    pc  = act_press[1];
    v   = 1'b1;
    len = 0;
    while (len < 40) begin
      int run;
      run = $urandom_range(1, 3);
      btn_raw[1] = v;
      tick(run);
      len += run;
      v = ~v;
    end
    if (v == 1'b0) begin
      btn_raw[1] = 1'b0;
      tick(1);
    end
    chk_int("bounce_no_press", act_press[1] - pc, 0);
    e = cyc;
    push_hold(1, e, 8);
    btn_raw[1] = 1'b1;
    tick(8);
    btn_raw[1] = 1'b0;
    to_cyc(e + 8 + LAT + 6);
    chk_int("bounce_one_press", act_press[1] - pc, 1);

    // Simultaneous press on channels 0 and 1
    e = cyc;
    push_hold(0, e, 8);
    push_hold(1, e, 8);
    btn_raw[1:0] = 2'b11;
    to_cyc(e + LAT - 1);
    @(negedge clk);
    tog_before = tog_o;
    to_cyc(e + LAT);
    @(negedge clk);
    chk("simul_press", press_o & 4'b0011, 4'b0011);
    to_cyc(e + LAT + 1);
    @(negedge clk);
    chk("simul_toggle", tog_o & 4'b0011, ~tog_before & 4'b0011);
    to_cyc(e + 8);
    btn_raw[1:0] = 2'b00;
    to_cyc(e + 8 + LAT + 6);

    // Reset mid-hold on channel 2 with the pin still held
    e = cyc;
    p = e + LAT;
    push_ev(p, 2, K_PRESS);
    btn_raw[2] = 1'b1;
    to_cyc(p + 9);
    rst = 1'b1;
    tick(1);
    rs  = cyc;
    rst = 1'b0;
    push_ev(rs + LAT, 2, K_PRESS);
    push_ev(rs + LAT + LONG, 2, K_LONG);
    push_ev(rs + LAT + LONG + REP, 2, K_REP);
    push_ev(rs + 30 + LAT, 2, K_REL);
    @(negedge clk);
    chk("reset_all_zero", level_o | press_o | release_o | long_o | rep_o | tog_o, 4'b0000);
    to_cyc(rs + LAT);
    @(negedge clk);
    chk("reset_repress", press_o, 4'b0100);
    to_cyc(rs + 30);
    btn_raw[2] = 1'b0;
    r = rs + 30 + LAT;
    to_cyc(r + 10);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events got=%0d want=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Multi-channel push-button front end: synchronises, debounces and edge-detects `N_BTN` asynchronous buttons. It also generates per-channel press/release pulses, a long-press pulse, an auto-repeat pulse train and a toggle state. It replaces single-button synchronise/debounce/toggle logic and sits between board pins and all user-input consumers, such as the OLED counter control and the LEDs.

## Interface
- `N_BTN`, 4, number of independent channels (>=1)
- `CLK_HZ`, 50_000_000, clock frequency in Hz
- `DEBOUNCE_MS`, 5, stability time before a level change is accepted (>=1)
- `LONG_MS`, 1000, hold time before `long_press` fires (>=1)
- `REPEAT_MS`, 200, auto-repeat period after long press; 0 disables repeat
- `ACTIVE_LOW`, '0 (N_BTN bits), per-channel mask; bit=1 inverts that raw input, so pressed always means 1 internally
- `clk_50`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `btn_raw`  in  N_BTN  asynchronous, bouncing button pins
- `level`  out  N_BTN  debounced pressed state
- `press`  out  N_BTN  1-cycle pulse on debounced press
- `release`  out  N_BTN  1-cycle pulse on debounced release
- `long_press`  out  N_BTN  1-cycle pulse once per hold reaching LONG_MS
- `repeat`  out  N_BTN  1-cycle pulses every REPEAT_MS after `long_press` while held
- `toggle`  out  N_BTN  flips on each `press`

## Operation
- Derived constants: DB_CYC = CLK_HZ/1000*DEBOUNCE_MS, LONG_CYC = CLK_HZ/1000*LONG_MS, REP_CYC = CLK_HZ/1000*REPEAT_MS. Each counter is $clog2(max+1) bits wide and never wraps.
- Per channel, the input path is: polarity XOR, then a 2-flop synchroniser (meta, sync), then the debouncer.
- Debouncer:
  - If sync == level, the counter clears.
  - Otherwise the counter increments. When it equals DB_CYC-1 on a mismatch cycle, level <= sync and the counter clears.
  - Any bounce back to level restarts the count.
- Edge outputs are combinational from registered state: `press` = level & ~level_d; `release` = ~level & level_d.
- Hold FSM per channel:
  - IDLE: wait for press; on press, clear hold_cnt and go to HOLD.
  - HOLD: hold_cnt increments each cycle while level = 1.
    - When hold_cnt reaches LONG_CYC-1, pulse `long_press` and move to REPEAT. If REPEAT_MS = 0, move to DONE instead.
  - REPEAT: rep_cnt increments. At REP_CYC-1, pulse `repeat` and clear rep_cnt.
  - DONE: wait for release.
  - From any state, level = 0 (release) returns the FSM to IDLE and clears both counters. No `long_press`/`repeat` fires in or after the release cycle.
- `toggle` inverts on every `press` cycle.
- Channels are fully independent. Simultaneous events on different channels all appear in the same cycle.

## Timing
- Reset (`rst`=1 at an edge) clears, on that edge: synchroniser flops, level, level_d, all counters, FSM to IDLE, and `toggle`. All outputs read 0 in the following cycle.
  - A button held through reset is treated as a new press: full synchroniser + debounce latency, then `press`.
  - Reset mid-debounce or mid-hold discards all progress.
- Debounce latency: if the pin is stable from before edge k, level changes after edge k+1+DB_CYC. `press`/`release` is high in the cycle immediately after that edge.
- Hold timing, with press high in cycle p:
  - `long_press` is high in cycle p+LONG_CYC.
  - `repeat` is high in cycles p+LONG_CYC+n*REP_CYC, n>=1.
- A press/release shorter than DB_CYC cycles produces no output change.
- Release and press on the same channel can never coincide; they are at least DB_CYC cycles apart.

## Test plan
All tests use CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=20, REPEAT_MS=5, N_BTN=4, ACTIVE_LOW=4'b1000 unless stated.

1. Clean press and release:
   - Stimulus: raw[0] goes to 1 before edge 10, is released before edge 30.
   - Required: level[0] rises after edge 15; `press[0]` is high in the cycle after edge 15; `toggle[0]`=1. `release[0]` is high in the cycle after edge 35.
2. Bounce rejection:
   - Stimulus: raw[1] toggles with 1-3 cycle pulses for 40 cycles, then holds 1.
   - Required: no output during bouncing; exactly one `press[1]` 5 cycles after the final stable edge.
3. Long press and repeat:
   - Stimulus: hold raw[2] for 50 cycles after `press`.
   - Required: `long_press[2]` at p+20; `repeat[2]` at p+25, 30, 35, 40, 45; nothing after release.
   - Variant: with REPEAT_MS=0, no `repeat` pulses.
4. Active-low channel:
   - Stimulus: raw[3] idles at 1, is driven to 0.
   - Required: `press[3]` and level[3]=1 after debounce; other channels remain 0.
5. Reset mid-hold:
   - Stimulus: assert `rst` for 1 cycle at p+10 on channel 2, with the raw input still held.
   - Required: all outputs 0 next cycle; new `press[2]` 5 cycles after reset is deasserted; `long_press` at 20 cycles after that press.
6. Simultaneous channels:
   - Stimulus: raw[0] and raw[1] pressed at the same edge.
   - Required: `press[0]` and `press[1]` are high in the same cycle; both `toggle` bits flip.
